// File: rtl/dot_product_sequencer.sv
// Streams a vector pair through a 4-bit MAC (A*B + acc), accumulating an
// 8-bit dot product with a sticky overflow flag and a valid/ready result port.
module dot_product_sequencer #(
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             abort_i,
    input  logic             elem_valid_i,
    output logic             elem_ready_o,
    input  logic [3:0]       a_i,
    input  logic [3:0]       b_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [7:0]       res_o,
    output logic             ovf_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [7:0]       acc;
    logic [LEN_W-1:0] cnt;
    logic             ovf;

    logic [7:0] prod;
    logic [8:0] sum;

    always_comb begin
        prod = a_i * b_i;
        sum  = {1'b0, prod} + {1'b0, acc};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        acc   <= '0;
                        ovf   <= 1'b0;
                        cnt   <= len_i;
                        state <= (len_i == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    // Abort takes priority so a same-cycle element is dropped.
                    if (abort_i) begin
                        state <= IDLE;
                    end else if (elem_valid_i) begin
                        acc <= sum[7:0];
                        ovf <= ovf | sum[8];
                        cnt <= cnt - 1'b1;
                        if (cnt == LEN_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (res_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs depend only on registered state, never directly on inputs.
    always_comb begin
        elem_ready_o = (state == RUN);
        res_valid_o  = (state == DONE);
        busy_o       = (state == RUN) || (state == DONE);
        res_o        = (state == DONE) ? acc : '0;
        ovf_o        = (state == DONE) ? ovf : 1'b0;
    end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer: table of whole operations plus
// hand-written sequences for gaps, backpressure, abort and reset.
module tb_dot_product_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic [3:0] len_i;
    logic       abort_i;
    logic       elem_valid_i;
    logic       elem_ready_o;
    logic [3:0] a_i;
    logic [3:0] b_i;
    logic       res_valid_o;
    logic       res_ready_i;
    logic [7:0] res_o;
    logic       ovf_o;
    logic       busy_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dot_product_sequencer #(.LEN_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .len_i        (len_i),
        .abort_i      (abort_i),
        .elem_valid_i (elem_valid_i),
        .elem_ready_o (elem_ready_o),
        .a_i          (a_i),
        .b_i          (b_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_o        (res_o),
        .ovf_o        (ovf_o),
        .busy_o       (busy_o)
    );

    typedef struct {
        logic [3:0]  len;
        logic [15:0] av;
        logic [15:0] bv;
        logic [7:0]  exp_res;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, ".ready"}, {8'd0, elem_ready_o}, 9'd0);
        check({name, ".valid"}, {8'd0, res_valid_o}, 9'd0);
        check({name, ".res"},   {1'b0, res_o}, 9'd0);
        check({name, ".ovf"},   {8'd0, ovf_o}, 9'd0);
        check({name, ".busy"},  {8'd0, busy_o}, 9'd0);
    endtask

    // One full operation, element every cycle, immediate acceptance.
    task automatic do_op(input string name, input logic [3:0] len, input logic [15:0] av,
                         input logic [15:0] bv, input logic [7:0] er, input logic eo);
        start_i = 1'b1;
        len_i   = len;
        step();
        start_i = 1'b0;
        len_i   = 4'd9;
        for (int unsigned i = 0; i < len; i++) begin
            check({name, ".ready"}, {8'd0, elem_ready_o}, 9'd1);
            check({name, ".early"}, {8'd0, res_valid_o}, 9'd0);
            elem_valid_i = 1'b1;
            a_i = av[i*4 +: 4];
            b_i = bv[i*4 +: 4];
            step();
        end
        elem_valid_i = 1'b0;
        check({name, ".valid"}, {8'd0, res_valid_o}, 9'd1);
        check({name, ".ready_done"}, {8'd0, elem_ready_o}, 9'd0);
        check({name, ".res"}, {1'b0, res_o}, {1'b0, er});
        check({name, ".ovf"}, {8'd0, ovf_o}, {8'd0, eo});
        res_ready_i = 1'b1;
        step();
        res_ready_i = 1'b0;
        check({name, ".after_accept"}, {8'd0, busy_o}, 9'd0);
    endtask

    initial begin
        vecs[0] = '{4'd2, 16'h0043, 16'h0065, 8'h27, 1'b0};
        vecs[1] = '{4'd2, 16'h00FF, 16'h00FF, 8'hC2, 1'b1};
        vecs[2] = '{4'd1, 16'h0001, 16'h0001, 8'h01, 1'b0};
        vecs[3] = '{4'd0, 16'h0000, 16'h0000, 8'h00, 1'b0};
        vecs[4] = '{4'd1, 16'h0007, 16'h0009, 8'h3F, 1'b0};
        vecs[5] = '{4'd3, 16'h0FFF, 16'h0FFF, 8'hA3, 1'b1};
        vecs[6] = '{4'd4, 16'h4321, 16'h1234, 8'h14, 1'b0};

        rst = 1'b1; start_i = 1'b0; len_i = '0; abort_i = 1'b0;
        elem_valid_i = 1'b0; a_i = '0; b_i = '0; res_ready_i = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_idle("reset");

        for (int unsigned v = 0; v < 7; v++) begin
            do_op($sformatf("vec%0d", v), vecs[v].len, vecs[v].av, vecs[v].bv,
                  vecs[v].exp_res, vecs[v].exp_ovf);
        end

        // Gaps on the element stream, then 4 cycles of backpressure.
        start_i = 1'b1; len_i = 4'd3; a_i = 4'd2; b_i = 4'd3;
        step();
        start_i = 1'b0;
        elem_valid_i = 1'b1; step();
        elem_valid_i = 1'b0; step(); step();
        check("gap.busy", {8'd0, busy_o}, 9'd1);
        check("gap.valid", {8'd0, res_valid_o}, 9'd0);
        elem_valid_i = 1'b1; step();
        elem_valid_i = 1'b0; step();
        elem_valid_i = 1'b1; step();
        elem_valid_i = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            check("hold.valid", {8'd0, res_valid_o}, 9'd1);
            check("hold.res", {1'b0, res_o}, 9'h012);
            start_i = (i == 1);
            len_i   = 4'd5;
            abort_i = (i == 2);
            step();
        end
        start_i = 1'b0; abort_i = 1'b0;
        check("hold.still", {8'd0, res_valid_o}, 9'd1);
        res_ready_i = 1'b1; start_i = 1'b1;
        step();
        res_ready_i = 1'b0; start_i = 1'b0;
        check_idle("accept");
        step();
        check_idle("accept_start_ignored");

        // Abort after first of three elements; the same-cycle element is dropped.
        start_i = 1'b1; len_i = 4'd3; a_i = 4'd1; b_i = 4'd1;
        step();
        start_i = 1'b0;
        elem_valid_i = 1'b1; step();
        abort_i = 1'b1; step();
        abort_i = 1'b0; elem_valid_i = 1'b0;
        check_idle("abort");
        step(); step();
        check("abort.no_result", {8'd0, res_valid_o}, 9'd0);

        // start_i/len_i pulsed during RUN must not restart or shorten the op.
        start_i = 1'b1; len_i = 4'd2;
        step();
        len_i = 4'd1;
        elem_valid_i = 1'b1; a_i = 4'd3; b_i = 4'd5;
        step();
        start_i = 1'b0;
        check("run_start.ready", {8'd0, elem_ready_o}, 9'd1);
        check("run_start.valid", {8'd0, res_valid_o}, 9'd0);
        a_i = 4'd4; b_i = 4'd6;
        step();
        elem_valid_i = 1'b0;
        check("run_start.res", {1'b0, res_o}, 9'h027);
        res_ready_i = 1'b1; step(); res_ready_i = 1'b0;

        // Reset mid-RUN.
        start_i = 1'b1; len_i = 4'd3; a_i = 4'd5; b_i = 4'd5;
        step();
        start_i = 1'b0;
        elem_valid_i = 1'b1; step();
        elem_valid_i = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        check_idle("rst_run");

        // Reset while a result is pending.
        start_i = 1'b1; len_i = 4'd0;
        step();
        start_i = 1'b0;
        check("len0.valid", {8'd0, res_valid_o}, 9'd1);
        rst = 1'b1; step(); rst = 1'b0;
        check_idle("rst_done");

        do_op("post_rst", 4'd1, 16'h0007, 16'h0009, 8'h3F, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
